// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      STALL
   } arb_state_t;

   // Explicit wrap so NUM_REQ need not be a power of two.
   function automatic int next_rr(input int ptr, input int num_req);
      return (ptr >= num_req - 1) ? 0 : ptr + 1;
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side handshakes plus FIFO write-port pins seen by the arbiter.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 24
);
   logic [NUM_REQ-1:0]                 req_valid;
   logic [NUM_REQ-1:0][DATA_WIDTH-1:0] req_data;
   logic [NUM_REQ-1:0]                 req_ready;
   logic                               fifo_full;
   logic                               fifo_almost_full;
   logic                               fifo_wr_en;
   logic [DATA_WIDTH-1:0]              fifo_data_in;
   logic [$clog2(NUM_REQ)-1:0]         grant_id;
   logic                               busy;

   modport master (
      input  req_valid, req_data, fifo_full, fifo_almost_full,
      output req_ready, fifo_wr_en, fifo_data_in, grant_id, busy
   );

   modport slave (
      output req_valid, req_data, fifo_full, fifo_almost_full,
      input  req_ready, fifo_wr_en, fifo_data_in, grant_id, busy
   );
endinterface

// File: rtl/rr_priority_pick.sv
// Combinational round-robin search: first set req_valid bit at or after start, wrapping.
module rr_priority_pick #(
   parameter int NUM_REQ = 2
) (
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [$clog2(NUM_REQ)-1:0] start,
   output logic                       hit,
   output logic [$clog2(NUM_REQ)-1:0] idx
);
   localparam int IDX_W = $clog2(NUM_REQ);

   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;

   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      hit  = 1'b0;
      idx  = start;
      sum  = '0;
      cand = '0;
      // Scan farthest offset first so the nearest valid requester overwrites the result last.
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         sum  = {1'b0, start} + (IDX_W + 1)'(i);
         cand = (sum >= (IDX_W + 1)'(NUM_REQ)) ? IDX_W'(sum - (IDX_W + 1)'(NUM_REQ))
                                                : IDX_W'(sum);
         if (req_valid[cand]) begin
            hit = 1'b1;
            idx = cand;
         end
      end
   end
endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port among NUM_REQ producers.
// Define FIFO_WR_ARB_BURST_EN to hold a grant for up to BURST_LEN consecutive transfers.
module fifo_wr_arbiter
   import fifo_arb_pkg::*;
#(
   parameter int NUM_REQ    = 2,
   parameter int DATA_WIDTH = 24,
   parameter int BURST_LEN  = 4
) (
   input  logic              clk,
   input  logic              reset,
   fifo_wr_arbiter_if.master bus
);
   localparam int IDX_W = $clog2(NUM_REQ);

   arb_state_t         state, state_n;
   logic [IDX_W-1:0]   rr_ptr, rr_ptr_n, grant_id, grant_id_n;
   logic [IDX_W-1:0]   rot_ptr, pick_start, pick_idx;
   logic               pick_hit, stall, transfer, hold;
   logic [NUM_REQ-1:0] req_ready;

   // fifo_full lags a cycle behind the FIFO, so the combinational flag is gated as well.
   assign stall      = bus.fifo_full | bus.fifo_almost_full;
   assign rot_ptr    = IDX_W'(next_rr(int'(grant_id), NUM_REQ));
   assign pick_start = (state == GRANT) ? rot_ptr : rr_ptr;

   rr_priority_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_valid (bus.req_valid),
      .start     (pick_start),
      .hit       (pick_hit),
      .idx       (pick_idx)
   );

   always_comb begin
      req_ready = '0;
      for (int i = 0; i < NUM_REQ; i++)
         req_ready[i] = (state == GRANT) && (grant_id == IDX_W'(i)) && !stall;
   end

   assign transfer         = req_ready[grant_id] & bus.req_valid[grant_id];
   assign bus.req_ready    = req_ready;
   assign bus.fifo_wr_en   = transfer;
   assign bus.fifo_data_in = transfer ? bus.req_data[grant_id] : {DATA_WIDTH{1'b0}};
   assign bus.grant_id     = grant_id;
   assign bus.busy         = (state != IDLE);

`ifdef FIFO_WR_ARB_BURST_EN
   localparam int CNT_W = $clog2(BURST_LEN + 1);
   logic [CNT_W-1:0] burst_cnt;

   assign hold = transfer && (burst_cnt < CNT_W'(BURST_LEN - 1));

   // Counter is untouched while stalled; any rotation clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         burst_cnt <= '0;
      else if (state == GRANT && !stall)
         burst_cnt <= hold ? burst_cnt + CNT_W'(1) : '0;
   end
`else
   assign hold = 1'b0;
`endif

   always_comb begin
      state_n    = state;
      rr_ptr_n   = rr_ptr;
      grant_id_n = grant_id;
      case (state)
         IDLE: begin
            if (pick_hit) begin
               grant_id_n = pick_idx;
               state_n    = GRANT;
            end
         end
         GRANT: begin
            if (stall) begin
               state_n = STALL;
            end else if (!hold) begin
               // Rotate and re-pick in the same cycle so alternating producers see no bubble.
               rr_ptr_n = rot_ptr;
               if (pick_hit) grant_id_n = pick_idx;
               else          state_n    = IDLE;
            end
         end
         STALL: begin
            if (!stall) state_n = GRANT;
         end
         default: state_n = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         rr_ptr   <= '0;
         grant_id <= '0;
      end else begin
         state    <= state_n;
         rr_ptr   <= rr_ptr_n;
         grant_id <= grant_id_n;
      end
   end

   a_params: assert property (@(posedge clk) (NUM_REQ >= 2) && (BURST_LEN >= 1));

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_proto
      a_hold: assert property (@(posedge clk) disable iff (reset)
         bus.req_valid[i] && !bus.req_ready[i] |=> bus.req_valid[i] && $stable(bus.req_data[i]));
   end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: random data, write-order model, directed timing checks.
module tb_fifo_wr_arbiter;
   localparam int NUM_REQ    = 2;
   localparam int DATA_WIDTH = 24;
   localparam int BURST_LEN  = 4;
   localparam int FIFO_DEPTH = 8;
`ifdef FIFO_WR_ARB_BURST_EN
   localparam bit BURST_ON = 1'b1;
`else
   localparam bit BURST_ON = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset = 1'b1;

   fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH)) bus ();

   fifo_wr_arbiter #(
      .NUM_REQ    (NUM_REQ),
      .DATA_WIDTH (DATA_WIDTH),
      .BURST_LEN  (BURST_LEN)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Producer word queues, write log and the order model state.
   logic [DATA_WIDTH-1:0] q0[$];
   logic [DATA_WIDTH-1:0] q1[$];
   int  wr_log[$];
   int  last_gnt, burst_n, occ;
   bit  fifo_model_en;

   logic [NUM_REQ-1:0]    s_ready;
   logic                  s_wr, s_busy;
   logic [DATA_WIDTH-1:0] s_data;
   logic [0:0]            s_gnt;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic bit pend(input int r);
      return (r == 0) ? (q0.size() != 0) : (q1.size() != 0);
   endfunction

   function automatic logic [DATA_WIDTH-1:0] head(input int r);
      return (r == 0) ? q0[0] : q1[0];
   endfunction

   // Continue the current burst if allowed, otherwise first pending requester after the last one.
   function automatic bit model_cont();
      return BURST_ON && burst_n > 0 && burst_n < BURST_LEN && pend(last_gnt);
   endfunction

   function automatic int model_next();
      if (model_cont()) return last_gnt;
      for (int k = 1; k <= NUM_REQ; k++)
         if (pend((last_gnt + k) % NUM_REQ)) return (last_gnt + k) % NUM_REQ;
      return -1;
   endfunction

   function automatic int exp_order(input int i);
      return BURST_ON ? (i / BURST_LEN) % NUM_REQ : i % NUM_REQ;
   endfunction

   task automatic drive_inputs();
      bus.req_valid[0] = (q0.size() != 0);
      bus.req_data[0]  = (q0.size() != 0) ? q0[0] : '0;
      bus.req_valid[1] = (q1.size() != 0);
      bus.req_data[1]  = (q1.size() != 0) ? q1[0] : '0;
   endtask

   task automatic update_fifo_flags();
      bus.fifo_full        = bus.fifo_almost_full;
      bus.fifo_almost_full = fifo_model_en && (occ >= FIFO_DEPTH);
   endtask

   task automatic load(input int n0, input int n1);
      for (int i = 0; i < n0; i++) q0.push_back(DATA_WIDTH'($urandom()));
      for (int i = 0; i < n1; i++) q1.push_back(DATA_WIDTH'($urandom()));
      drive_inputs();
   endtask

   // Sample at negedge, score any write against the model, then advance inputs after the edge.
   task automatic cycle();
      logic [NUM_REQ-1:0] acc;
      bit cont;
      int nx, wid;
      wid = -1;
      @(negedge clk);
      s_ready = bus.req_ready;
      s_wr    = bus.fifo_wr_en;
      s_data  = bus.fifo_data_in;
      s_gnt   = bus.grant_id;
      s_busy  = bus.busy;
      acc     = s_ready & bus.req_valid;
      if (bus.fifo_full || bus.fifo_almost_full) check("ready_while_full", 32'(s_ready), 0);
      if (acc != '0) begin
         nx   = model_next();
         cont = model_cont();
         wid  = acc[1] ? 1 : 0;
         check("winner", 32'(acc), (nx >= 0) ? (32'd1 << nx) : 32'd0);
         check("wr_en", 32'(s_wr), 1);
         check("data_in", 32'(s_data), 32'(head(wid)));
         burst_n  = (cont && wid == last_gnt) ? burst_n + 1 : 1;
         last_gnt = wid;
         wr_log.push_back(wid);
      end else begin
         check("idle_wr_en", 32'(s_wr), 0);
         check("idle_data_in", 32'(s_data), 0);
      end
      @(posedge clk);
      #1;
      if (wid == 0) void'(q0.pop_front());
      else if (wid == 1) void'(q1.pop_front());
      if (wid >= 0 && fifo_model_en) occ++;
      update_fifo_flags();
      drive_inputs();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      q0.delete();
      q1.delete();
      last_gnt = NUM_REQ - 1;
      burst_n  = 0;
      occ      = 0;
      fifo_model_en        = 1'b0;
      bus.fifo_full        = 1'b0;
      bus.fifo_almost_full = 1'b0;
      drive_inputs();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   task automatic run_writes(input int base, input int target, input int budget, output int cyc);
      cyc = 0;
      while ((wr_log.size() - base) < target && cyc < budget) begin
         cycle();
         cyc++;
      end
   endtask

   initial begin
      int base, cyc, exp_gnt, resume_idx;
      bus.req_valid = '0;
      bus.req_data  = '0;
      bus.fifo_full = 1'b0;
      bus.fifo_almost_full = 1'b0;

      // Reset values, then reset asserted during a live transfer.
      do_reset();
      cycle();
      check("rst_busy", 32'(s_busy), 0);
      check("rst_grant", 32'(s_gnt), 0);
      check("rst_ready", 32'(s_ready), 0);
      load(3, 3);
      base = wr_log.size();
      run_writes(base, 1, 10, cyc);
      check("pre_rst_write", wr_log.size() - base, 1);
      #2;
      check("mid_xfer_accept", 32'(bus.req_ready & bus.req_valid), 32'd1 << model_next());
      reset = 1'b1;
      #1;
      check("async_rst_ready", 32'(bus.req_ready), 0);
      check("async_rst_wr_en", 32'(bus.fifo_wr_en), 0);
      check("async_rst_data", 32'(bus.fifo_data_in), 0);
      check("async_rst_busy", 32'(bus.busy), 0);
      check("async_rst_grant", 32'(bus.grant_id), 0);
      do_reset();
      cycle();
      check("post_rst_busy", 32'(s_busy), 0);
      check("post_rst_grant", 32'(s_gnt), 0);
      check("no_partial_write", wr_log.size() - base, 1);

      // Single word: ready one cycle after valid is first seen in IDLE.
      do_reset();
      q0.push_back(24'hA5A5A5);
      drive_inputs();
      cycle();
      check("lat_idle_ready", 32'(s_ready), 0);
      check("lat_idle_busy", 32'(s_busy), 0);
      cycle();
      check("single_ready", 32'(s_ready), 1);
      check("single_wr_en", 32'(s_wr), 1);
      check("single_data", 32'(s_data), 32'hA5A5A5);
      cycle();
      cycle();
      check("single_back_idle", 32'(s_busy), 0);

      // Both continuously valid: fair rotation (or bursts) with no bubbles.
      do_reset();
      load(8, 8);
      base = wr_log.size();
      run_writes(base, 16, 40, cyc);
      check("fair_writes", wr_log.size() - base, 16);
      check("fair_cycles", cyc, 17);
      for (int i = 0; i < 16; i++) check("fair_order", wr_log[base + i], exp_order(i));

      // FIFO fills after 8 writes: grant held while stalled, then resumes without loss.
      do_reset();
      load(6, 6);
      fifo_model_en = 1'b1;
      base = wr_log.size();
      run_writes(base, 8, 40, cyc);
      check("fill_writes", wr_log.size() - base, 8);
      exp_gnt = model_next();
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("stall_wr_en", 32'(s_wr), 0);
         check("stall_grant", 32'(s_gnt), exp_gnt);
         check("stall_busy", 32'(s_busy), 1);
      end
      fifo_model_en = 1'b0;
      occ = 0;
      bus.fifo_almost_full = 1'b0;
      resume_idx = wr_log.size();
      run_writes(base, 12, 40, cyc);
      check("drain_writes", wr_log.size() - base, 12);
      check("resume_grant", wr_log[resume_idx], exp_gnt);
      check("drain_empty", q0.size() + q1.size(), 0);

      // Requester 0 runs dry early while requester 1 waits.
      do_reset();
      load(2, 4);
      base = wr_log.size();
`ifdef FIFO_WR_ARB_BURST_EN
      run_writes(base, 2, 20, cyc);
      check("drop_first_two", wr_log[base + 1], 0);
      cycle();
      check("drop_gap_wr", 32'(s_wr), 0);
      check("drop_gap_grant", 32'(s_gnt), 0);
      cycle();
      check("drop_next_grant", 32'(s_gnt), 1);
      check("drop_next_wr", 32'(s_wr), 1);
`else
      run_writes(base, 1, 20, cyc);
      cycle();
      check("rotate_grant", 32'(s_gnt), 1);
      check("rotate_wr", 32'(s_wr), 1);
`endif
      run_writes(base, 6, 40, cyc);
      check("drop_total", wr_log.size() - base, 6);
      check("drop_empty", q0.size() + q1.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
